// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch/decode front end
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

  localparam word_t RESET_VECTOR = 32'h0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic word_t word_align(word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - imem request/response, redirect and decode handshake bundle
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  word_t imem_req_addr;
  logic  imem_resp_valid;
  word_t imem_resp_data;
  logic  redirect_valid;
  word_t redirect_pc;
  logic  instr_valid;
  word_t instr;
  word_t instr_pc;
  logic  instr_ready;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of {instr, pc} entries; flush beats push/pop
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  fetch_entry_t     mem_q [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= next_ptr(tail_q);
      if (do_pop)  head_q <= next_ptr(head_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Payload needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, credit-limited imem requests, stale-response discard, decode buffer
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC   = RESET_VECTOR,
  parameter int    FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  word_t            pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d, disc_q, disc_d;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             req_fire, credit_ok;
  fetch_entry_t     head;

  // Every in-flight request owns a buffer slot, so responses never need backpressure.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);

  assign bus.imem_req_valid = !reset && credit_ok;
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign fifo_push = bus.imem_resp_valid && (disc_q == '0) && !bus.redirect_valid && !fifo_full;
  assign fifo_pop  = !fifo_empty && bus.instr_ready && !bus.redirect_valid;

  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    disc_d    = disc_q;
    outst_d   = outst_q + CNT_W'(req_fire) - CNT_W'(bus.imem_resp_valid);
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle belongs to the abandoned path.
      pc_d      = word_align(bus.redirect_pc);
      resp_pc_d = word_align(bus.redirect_pc);
      disc_d    = outst_d;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (bus.imem_resp_valid) begin
        if (disc_q != '0) disc_d = disc_q - 1'b1;
        else              resp_pc_d = resp_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      disc_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      disc_q    <= disc_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (fifo_push),
    .push_data_i ('{instr: bus.imem_resp_data, pc: resp_pc_q}),
    .pop_i       (fifo_pop),
    .flush_i     (bus.redirect_valid),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit with an in-order memory and stream model
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  req_t        pend[$];
  ent_t        buff[$];
  logic [31:0] exp_req_pc;
  int          cyc;
  int          n_vec;
  int          n_err;
  int          n_acc;
  logic        obs_rv, obs_iv;
  logic [31:0] obs_addr, obs_ipc;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.instr_ready     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    #1;
    chk("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
    chk("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    pend.delete();
    buff.delete();
    exp_req_pc = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock of stimulus; the model advances with what the clock edge will do.
  task automatic step(input bit rrdy, input bit irdy, input bit redir,
                      input logic [31:0] rpc, input int lat);
    bit   resp, exp_rv, fire;
    req_t r;
    ent_t e;
    @(negedge clk);
    resp = (pend.size() > 0) && (pend[0].due <= cyc);
    bus.imem_req_ready  = rrdy;
    bus.instr_ready     = irdy;
    bus.redirect_valid  = redir;
    bus.redirect_pc     = rpc;
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = resp ? mem_word(pend[0].addr) : $urandom;
    #1;
    obs_rv   = bus.imem_req_valid;
    obs_addr = bus.imem_req_addr;
    obs_iv   = bus.instr_valid;
    obs_ipc  = bus.instr_pc;
    exp_rv   = (pend.size() + buff.size()) < DEPTH;
    chk("req_valid", {31'h0, obs_rv}, {31'h0, exp_rv});
    if (exp_rv) chk("req_addr", obs_addr, exp_req_pc);
    chk("instr_valid", {31'h0, obs_iv}, {31'h0, buff.size() > 0});
    if (buff.size() > 0) begin
      chk("instr_pc", obs_ipc, buff[0].pc);
      chk("instr", bus.instr, buff[0].instr);
    end
    if (obs_rv && rrdy) n_acc++;
    fire = exp_rv && rrdy;
    if (buff.size() > 0 && irdy && !redir) void'(buff.pop_front());
    if (resp) begin
      r = pend.pop_front();
      if (!r.stale && !redir) begin
        e.instr = mem_word(r.addr);
        e.pc    = r.addr;
        buff.push_back(e);
      end
    end
    if (fire) begin
      r.addr  = exp_req_pc;
      r.due   = cyc + lat;
      r.stale = redir;
      pend.push_back(r);
    end
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      buff.delete();
      exp_req_pc = {rpc[31:2], 2'b00};
    end else if (fire) begin
      exp_req_pc = exp_req_pc + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    bit got_iv, got_req;
    n_vec = 0;
    n_err = 0;
    n_acc = 0;
    cyc   = 0;
    exp_req_pc = 32'h0;
    drive_idle();

    // Straight-line fetch with single-cycle memory
    do_reset();
    step(1, 1, 0, 32'h0, 1);
    chk("t1_first_req_valid", {31'h0, obs_rv}, 32'h1);
    chk("t1_first_addr", obs_addr, 32'h0);
    step(1, 1, 0, 32'h0, 1);
    chk("t1_second_addr", obs_addr, 32'h4);
    chk("t1_no_instr_yet", {31'h0, obs_iv}, 32'h0);
    step(1, 1, 0, 32'h0, 1);
    chk("t1_first_instr_valid", {31'h0, obs_iv}, 32'h1);
    chk("t1_first_instr_pc", obs_ipc, 32'h0);
    repeat (6) step(1, 1, 0, 32'h0, 1);

    // Decoder stalled: exactly FIFO_DEPTH requests, then drain in order
    do_reset();
    n_acc = 0;
    repeat (6) step(1, 0, 0, 32'h0, 1);
    chk("t2_accepts", n_acc, DEPTH);
    chk("t2_req_blocked", {31'h0, obs_rv}, 32'h0);
    step(1, 1, 0, 32'h0, 1);
    chk("t2_head_pc", obs_ipc, 32'h0);
    step(1, 1, 0, 32'h0, 1);
    chk("t2_next_pc", obs_ipc, 32'h4);
    chk("t2_resume_valid", {31'h0, obs_rv}, 32'h1);
    chk("t2_resume_addr", obs_addr, 32'h8);

    // Memory not ready: request held stable
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 32'h0, 1);
      chk("t3_hold_valid", {31'h0, obs_rv}, 32'h1);
      chk("t3_hold_addr", obs_addr, 32'h0);
    end

    // Redirect with two slow requests in flight
    step(1, 1, 0, 32'h0, 6);
    step(1, 1, 0, 32'h0, 6);
    step(0, 1, 1, 32'h103, 1);
    got_iv = 0;
    got_req = 0;
    for (int i = 0; i < 40 && !got_iv; i++) begin
      step(1, 1, 0, 32'h0, 1);
      if (!got_req && obs_rv) begin
        got_req = 1;
        chk("t4_first_req_addr", obs_addr, 32'h100);
      end
      if (obs_iv) begin
        got_iv = 1;
        chk("t4_first_instr_pc", obs_ipc, 32'h100);
      end
    end
    chk("t4_instr_arrived", {31'h0, got_iv}, 32'h1);

    // Redirect coinciding with an accept and a response
    do_reset();
    step(1, 1, 0, 32'h0, 1);
    step(1, 1, 1, 32'h200, 1);
    got_iv = 0;
    for (int i = 0; i < 40 && !got_iv; i++) begin
      step(1, 1, 0, 32'h0, 1);
      if (obs_iv) begin
        got_iv = 1;
        chk("t5_first_instr_pc", obs_ipc, 32'h200);
      end
    end
    chk("t5_instr_arrived", {31'h0, got_iv}, 32'h1);

    // Reset with a full buffer
    do_reset();
    repeat (6) step(1, 0, 0, 32'h0, 1);
    chk("t6_buffer_full_valid", {31'h0, obs_iv}, 32'h1);
    do_reset();
    step(1, 1, 0, 32'h0, 1);
    chk("t6_restart_addr", obs_addr, 32'h0);
    chk("t6_restart_valid", {31'h0, obs_rv}, 32'h1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom, $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
